// File: rtl/spmv_pkg.sv
// Shared types, field positions and helpers for the SpMV kernel launcher.
package spmv_pkg;

   localparam int unsigned WORD_W    = 32;
   localparam int unsigned CFG_WORDS = 3;
   localparam int unsigned STS_WORDS = 2;

   localparam int unsigned CTRL_START_BIT = 0;
   localparam int unsigned CTRL_ABORT_BIT = 1;

   localparam int unsigned ST_DONE         = 3;
   localparam int unsigned ST_ERR_MISMATCH = 4;
   localparam int unsigned ST_ERR_TIMEOUT  = 5;
   localparam int unsigned ST_ABORTED      = 6;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_RUN    = 2'd2,
      S_DONE   = 2'd3
   } kseq_state_e;

   typedef struct packed {
      logic aborted;
      logic err_timeout;
      logic err_mismatch;
      logic done;
   } kseq_flags_t;

   function automatic logic [WORD_W-1:0] sat_inc(input logic [WORD_W-1:0] v);
      return (v == '1) ? v : v + WORD_W'(1);
   endfunction

   // Software-visible status word: state in [2:0], sticky flags above it.
   function automatic logic [WORD_W-1:0] pack_status(input kseq_state_e st,
                                                     input kseq_flags_t f);
      logic [WORD_W-1:0] w;
      w                  = '0;
      w[2:0]             = {1'b0, st};
      w[ST_DONE]         = f.done;
      w[ST_ERR_MISMATCH] = f.err_mismatch;
      w[ST_ERR_TIMEOUT]  = f.err_timeout;
      w[ST_ABORTED]      = f.aborted;
      return w;
   endfunction

endpackage

// File: rtl/spmv_kernel_seq.sv
// One kernel sequencer: start/ready launch handshake, row progress tracking,
// completion, abort and idle timeout detection.
module spmv_kernel_seq
   import spmv_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 32'd1_000_000
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [WORD_W-1:0] row_num_i,
   input  logic [WORD_W-1:0] nnz_num_i,
   input  logic              kern_ready_i,
   input  logic              kern_row_done_i,
   input  logic              kern_done_i,
   output logic              kern_start_o,
   output logic              kern_abort_o,
   output logic [WORD_W-1:0] kern_row_num_o,
   output logic [WORD_W-1:0] kern_nnz_num_o,
   output logic [WORD_W-1:0] status_o,
   output logic [WORD_W-1:0] rows_done_o
);

   localparam logic [WORD_W-1:0] TIMEOUT_W  = WORD_W'(TIMEOUT_CYCLES);
   localparam bit                TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

   kseq_state_e       state_q, state_d;
   kseq_flags_t       flags_q, flags_d;
   logic              start_q, start_d;
   logic              kern_start_q, kern_start_d;
   logic              kern_abort_q, kern_abort_d;
   logic [WORD_W-1:0] row_num_q, row_num_d;
   logic [WORD_W-1:0] nnz_num_q, nnz_num_d;
   logic [WORD_W-1:0] rows_done_q, rows_done_d;
   logic [WORD_W-1:0] idle_cnt_q, idle_cnt_d;
   logic [WORD_W-1:0] status_q, status_d;

   logic              start_edge_c;
   logic [WORD_W-1:0] rows_next_c;
   logic [WORD_W-1:0] idle_inc_c;
   logic              timeout_hit_c;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         flags_q      <= '0;
         start_q      <= 1'b0;
         kern_start_q <= 1'b0;
         kern_abort_q <= 1'b0;
         row_num_q    <= '0;
         nnz_num_q    <= '0;
         rows_done_q  <= '0;
         idle_cnt_q   <= '0;
         status_q     <= '0;
      end else begin
         state_q      <= state_d;
         flags_q      <= flags_d;
         start_q      <= start_d;
         kern_start_q <= kern_start_d;
         kern_abort_q <= kern_abort_d;
         row_num_q    <= row_num_d;
         nnz_num_q    <= nnz_num_d;
         rows_done_q  <= rows_done_d;
         idle_cnt_q   <= idle_cnt_d;
         status_q     <= status_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      flags_d      = flags_q;
      start_d      = start_i;
      kern_abort_d = 1'b0;
      row_num_d    = row_num_q;
      nnz_num_d    = nnz_num_q;
      rows_done_d  = rows_done_q;
      idle_cnt_d   = idle_cnt_q;
      status_d     = pack_status(state_q, flags_q);

      start_edge_c  = start_i & ~start_q;
      rows_next_c   = kern_row_done_i ? sat_inc(rows_done_q) : rows_done_q;
      idle_inc_c    = idle_cnt_q + WORD_W'(1);
      timeout_hit_c = TIMEOUT_EN && !kern_row_done_i && (idle_inc_c == TIMEOUT_W);

      case (state_q)
         S_IDLE: begin
            if (start_edge_c) begin
               row_num_d   = row_num_i;
               nnz_num_d   = nnz_num_i;
               rows_done_d = '0;
               idle_cnt_d  = '0;
               flags_d     = '0;
               if (row_num_i == '0) begin
                  state_d      = S_DONE;
                  flags_d.done = 1'b1;
               end else begin
                  state_d = S_LAUNCH;
               end
            end
         end
         S_LAUNCH: begin
            if (abort_i) begin
               state_d         = S_DONE;
               kern_abort_d    = 1'b1;
               flags_d.aborted = 1'b1;
            end else if (kern_ready_i) begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            rows_done_d = rows_next_c;
            idle_cnt_d  = kern_row_done_i ? '0 : idle_inc_c;
            if (rows_next_c > row_num_q) begin
               flags_d.err_mismatch = 1'b1;
            end
            // A row retired alongside kern_done is already in rows_next_c.
            if (kern_done_i) begin
               state_d      = S_DONE;
               flags_d.done = 1'b1;
               if (rows_next_c != row_num_q) begin
                  flags_d.err_mismatch = 1'b1;
               end
            end else if (abort_i) begin
               state_d         = S_DONE;
               kern_abort_d    = 1'b1;
               flags_d.aborted = 1'b1;
            end else if (timeout_hit_c) begin
               state_d             = S_DONE;
               kern_abort_d        = 1'b1;
               flags_d.err_timeout = 1'b1;
            end
         end
         S_DONE: begin
            if (!start_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      kern_start_d = (state_d == S_LAUNCH);
   end

   assign kern_start_o   = kern_start_q;
   assign kern_abort_o   = kern_abort_q;
   assign kern_row_num_o = row_num_q;
   assign kern_nnz_num_o = nnz_num_q;
   assign status_o       = status_q;
   assign rows_done_o    = rows_done_q;

endmodule

// File: rtl/spmv_kernel_launcher.sv
// Per-kernel launch sequencers between the SpMV register block and the
// compute kernels; slices the flat config/status buses.
module spmv_kernel_launcher
   import spmv_pkg::*;
#(
   parameter int unsigned CONF_NUM_KERNEL = 4,
   parameter int unsigned TIMEOUT_CYCLES  = 32'd1_000_000
) (
   input  logic                                      aclk,
   input  logic                                      aresetn,
   input  logic [CFG_WORDS*WORD_W*CONF_NUM_KERNEL-1:0] config_wire,
   output logic [CONF_NUM_KERNEL-1:0]                kern_start,
   input  logic [CONF_NUM_KERNEL-1:0]                kern_ready,
   output logic [WORD_W*CONF_NUM_KERNEL-1:0]         kern_row_num,
   output logic [WORD_W*CONF_NUM_KERNEL-1:0]         kern_nnz_num,
   input  logic [CONF_NUM_KERNEL-1:0]                kern_row_done,
   input  logic [CONF_NUM_KERNEL-1:0]                kern_done,
   output logic [CONF_NUM_KERNEL-1:0]                kern_abort,
   output logic [STS_WORDS*WORD_W*CONF_NUM_KERNEL-1:0] status_wire
);

   for (genvar i = 0; i < CONF_NUM_KERNEL; i++) begin : g_kern
      localparam int unsigned CFG_BASE = CFG_WORDS * WORD_W * i;
      localparam int unsigned STS_BASE = STS_WORDS * WORD_W * i;

      logic [WORD_W-1:0] ctrl;
      logic              unused_ctrl;

      assign ctrl        = config_wire[CFG_BASE +: WORD_W];
      // Only start and abort are meaningful in the ctrl word.
      assign unused_ctrl = ^ctrl[WORD_W-1:CTRL_ABORT_BIT+1];

      spmv_kernel_seq #(
         .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
      ) u_seq (
         .clk_i          (aclk),
         .rst_ni         (aresetn),
         .start_i        (ctrl[CTRL_START_BIT]),
         .abort_i        (ctrl[CTRL_ABORT_BIT]),
         .row_num_i      (config_wire[CFG_BASE + WORD_W +: WORD_W]),
         .nnz_num_i      (config_wire[CFG_BASE + 2*WORD_W +: WORD_W]),
         .kern_ready_i   (kern_ready[i]),
         .kern_row_done_i(kern_row_done[i]),
         .kern_done_i    (kern_done[i]),
         .kern_start_o   (kern_start[i]),
         .kern_abort_o   (kern_abort[i]),
         .kern_row_num_o (kern_row_num[WORD_W*i +: WORD_W]),
         .kern_nnz_num_o (kern_nnz_num[WORD_W*i +: WORD_W]),
         .status_o       (status_wire[STS_BASE +: WORD_W]),
         .rows_done_o    (status_wire[STS_BASE + WORD_W +: WORD_W])
      );
   end

endmodule

// File: tb/tb_spmv_kernel_launcher.sv
// Randomized job-level bench for spmv_kernel_launcher: each job's outcome
// (status flags, rows counted, handshake timing) is predicted from the job's shape.
module tb_spmv_kernel_launcher;

   localparam int K   = 4;
   localparam int TMO = 16;

   logic            aclk;
   logic            aresetn;
   logic [96*K-1:0] config_wire;
   logic [K-1:0]    kern_start, kern_ready, kern_row_done, kern_done, kern_abort;
   logic [32*K-1:0] kern_row_num, kern_nnz_num;
   logic [64*K-1:0] status_wire;

   logic [31:0] ctrl_r [K];
   logic [31:0] row_r  [K];
   logic [31:0] nnz_r  [K];
   logic        ready_r   [K];
   logic        rowdone_r [K];
   logic        done_r    [K];

   logic [31:0] exp_sts  [K];
   logic [31:0] exp_rows [K];

   int n_vec;
   int n_err;

   spmv_kernel_launcher #(
      .CONF_NUM_KERNEL(K),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .config_wire  (config_wire),
      .kern_start   (kern_start),
      .kern_ready   (kern_ready),
      .kern_row_num (kern_row_num),
      .kern_nnz_num (kern_nnz_num),
      .kern_row_done(kern_row_done),
      .kern_done    (kern_done),
      .kern_abort   (kern_abort),
      .status_wire  (status_wire)
   );

   always #5 aclk = ~aclk;

   always_comb begin
      for (int i = 0; i < K; i++) begin
         config_wire[96*i +: 32]      = ctrl_r[i];
         config_wire[96*i + 32 +: 32] = row_r[i];
         config_wire[96*i + 64 +: 32] = nnz_r[i];
         kern_ready[i]                = ready_r[i];
         kern_row_done[i]             = rowdone_r[i];
         kern_done[i]                 = done_r[i];
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   function automatic logic [31:0] sts(input int k);
      return status_wire[64*k +: 32];
   endfunction

   function automatic logic [31:0] rdn(input int k);
      return status_wire[64*k + 32 +: 32];
   endfunction

   function automatic logic [31:0] mk_status(input int st, input bit d, input bit mm,
                                             input bit to, input bit ab);
      return 32'(st) | (32'(d) << 3) | (32'(mm) << 4) | (32'(to) << 5) | (32'(ab) << 6);
   endfunction

   task automatic check_all_model(input string tag);
      for (int j = 0; j < K; j++) begin
         check_eq({tag, "_sts"}, sts(j), exp_sts[j]);
         check_eq({tag, "_rows"}, rdn(j), exp_rows[j]);
      end
   endtask

   // mode: 0 done, 1 done with last row, 2 abort in LAUNCH, 3 abort in RUN,
   //       4 idle timeout, 5 abort together with done
   task automatic run_job(input int k, input logic [31:0] rows, input logic [31:0] nnz,
                          input int rdy, input int np, input int mode, input bit chk_others);
      int          p_tot;
      int          n_body;
      bit          f_done, f_mm, f_to, f_ab;
      logic [31:0] exp_st;
      p_tot  = 0;
      f_done = 0; f_mm = 0; f_to = 0; f_ab = 0;
      ctrl_r[k] = '0; row_r[k] = rows; nnz_r[k] = nnz;
      tick();
      ctrl_r[k][0] = 1'b1;
      tick();
      row_r[k] = $urandom; nnz_r[k] = $urandom;
      if (rows == 0) begin
         check_eq("zero_row_start", 32'(kern_start[k]), 0);
         f_done = 1;
      end else begin
         for (int c = 1; c <= rdy; c++) begin
            check_eq("start_high", 32'(kern_start[k]), 1);
            check_eq("row_latched", kern_row_num[32*k +: 32], rows);
            if (c == rdy) begin
               if (mode == 2) begin
                  ctrl_r[k][1] = 1'b1;
                  ready_r[k]   = 1'($urandom_range(0, 1));
               end else begin
                  ready_r[k] = 1'b1;
               end
            end
            tick();
            ready_r[k] = 1'b0;
         end
         check_eq("start_low", 32'(kern_start[k]), 0);
         if (mode == 2) begin
            check_eq("launch_abort", 32'(kern_abort[k]), 1);
            ctrl_r[k][1] = 1'b0;
            f_ab = 1;
         end else begin
            n_body = (mode == 1) ? np - 1 : np;
            for (int n = 0; n < n_body; n++) begin
               repeat ($urandom_range(0, 6)) tick();
               rowdone_r[k] = 1'b1;
               tick();
               rowdone_r[k] = 1'b0;
               p_tot++;
            end
            if (mode != 4) repeat ($urandom_range(0, 6)) tick();
            case (mode)
               0: begin
                  done_r[k] = 1'b1; tick(); done_r[k] = 1'b0;
                  check_eq("done_no_abort", 32'(kern_abort[k]), 0);
                  f_done = 1;
               end
               1: begin
                  done_r[k] = 1'b1; rowdone_r[k] = 1'b1; tick();
                  done_r[k] = 1'b0; rowdone_r[k] = 1'b0;
                  p_tot++;
                  f_done = 1;
               end
               3: begin
                  ctrl_r[k][1] = 1'b1; tick(); ctrl_r[k][1] = 1'b0;
                  check_eq("run_abort", 32'(kern_abort[k]), 1);
                  f_ab = 1;
               end
               4: begin
                  for (int c = 1; c <= TMO; c++) begin
                     tick();
                     check_eq("timeout_abort", 32'(kern_abort[k]), 32'(c == TMO));
                  end
                  f_to = 1;
               end
               default: begin
                  ctrl_r[k][1] = 1'b1; done_r[k] = 1'b1; tick();
                  ctrl_r[k][1] = 1'b0; done_r[k] = 1'b0;
                  check_eq("done_beats_abort", 32'(kern_abort[k]), 0);
                  f_done = 1;
               end
            endcase
         end
      end
      f_mm   = f_done ? (p_tot != int'(rows)) : (p_tot > int'(rows));
      exp_st = mk_status(3, f_done, f_mm, f_to, f_ab);
      tick();
      check_eq("abort_one_cycle", 32'(kern_abort[k]), 0);
      check_eq("status_final", sts(k), exp_st);
      check_eq("rows_done_final", rdn(k), 32'(p_tot));
      check_eq("row_hold", kern_row_num[32*k +: 32], rows);
      check_eq("nnz_hold", kern_nnz_num[32*k +: 32], nnz);
      rowdone_r[k] = 1'b1; done_r[k] = 1'b1;
      tick();
      rowdone_r[k] = 1'b0; done_r[k] = 1'b0;
      tick();
      check_eq("done_ignores_rows", rdn(k), 32'(p_tot));
      check_eq("done_status_held", sts(k), exp_st);
      ctrl_r[k] = '0;
      tick();
      tick();
      check_eq("idle_flags_kept", sts(k), exp_st & ~32'h7);
      exp_sts[k]  = exp_st & ~32'h7;
      exp_rows[k] = 32'(p_tot);
      if (chk_others) check_all_model("others");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          k, mode, np, rdy;
      logic [31:0] rows;
      n_vec = 0;
      n_err = 0;
      aclk    = 1'b0;
      aresetn = 1'b0;
      for (int i = 0; i < K; i++) begin
         ctrl_r[i] = '0; row_r[i] = '0; nnz_r[i] = '0;
         ready_r[i] = 1'b0; rowdone_r[i] = 1'b0; done_r[i] = 1'b0;
         exp_sts[i] = '0; exp_rows[i] = '0;
      end
      tick();
      tick();
      aresetn = 1'b1;
      check_eq("rst_start", 32'(kern_start), 0);
      check_eq("rst_abort", 32'(kern_abort), 0);
      check_eq("rst_rownum", kern_row_num[31:0], 0);
      check_all_model("rst");

      run_job(0, 4, 10, 3, 4, 0, 1);
      run_job(1, 0, 7, 1, 0, 0, 1);
      run_job(2, 5, 9, 2, 4, 1, 1);
      run_job(3, 3, 3, 1, 1, 4, 1);
      run_job(0, 2, 4, 2, 2, 5, 1);
      run_job(1, 6, 6, 2, 0, 2, 1);

      // Reset mid-RUN with start still held.
      ctrl_r[0] = '0; row_r[0] = 32'd6; nnz_r[0] = 32'd11;
      tick();
      ctrl_r[0][0] = 1'b1;
      tick();
      ready_r[0] = 1'b1; tick(); ready_r[0] = 1'b0;
      rowdone_r[0] = 1'b1; tick(); rowdone_r[0] = 1'b0;
      tick();
      aresetn = 1'b0;
      tick();
      aresetn = 1'b1;
      for (int i = 0; i < K; i++) begin
         exp_sts[i] = '0; exp_rows[i] = '0;
      end
      check_eq("mid_rst_start", 32'(kern_start), 0);
      check_eq("mid_rst_abort", 32'(kern_abort), 0);
      check_eq("mid_rst_rownum", kern_row_num[31:0], 0);
      check_eq("mid_rst_nnz", kern_nnz_num[31:0], 0);
      check_all_model("mid_rst");
      tick();
      check_eq("relaunch_start", 32'(kern_start[0]), 1);
      check_eq("relaunch_rownum", kern_row_num[31:0], 6);
      ready_r[0] = 1'b1; tick(); ready_r[0] = 1'b0;
      repeat (6) begin
         rowdone_r[0] = 1'b1; tick(); rowdone_r[0] = 1'b0; tick();
      end
      done_r[0] = 1'b1; tick(); done_r[0] = 1'b0;
      tick();
      check_eq("relaunch_status", sts(0), 32'h0B);
      check_eq("relaunch_rows", rdn(0), 6);
      ctrl_r[0] = '0;
      tick();
      tick();
      exp_sts[0] = 32'h08; exp_rows[0] = 32'd6;
      check_all_model("post_relaunch");

      fork
         run_job(0, 5, 21, 2, 5, 0, 0);
         run_job(1, 3, 8, 4, 3, 1, 0);
      join
      check_all_model("parallel");

      repeat (40) begin
         k    = $urandom_range(0, K - 1);
         rows = ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 8));
         rdy  = $urandom_range(1, 5);
         mode = $urandom_range(0, 5);
         np   = ($urandom_range(0, 2) != 0) ? int'(rows) : $urandom_range(0, int'(rows) + 2);
         if (mode == 1 && np == 0) np = 1;
         run_job(k, rows, $urandom, rdy, np, mode, 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
